// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with a double-buffered display value.
// Optional: define SEG_LZ_SUPPRESS_EN to blank leading-zero digits.
module seg_scan_display #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2500,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    r_div_cnt;
    logic [IDX_W-1:0]    r_idx;

    logic [4*DIGITS-1:0] r_act_data;
    logic [DIGITS-1:0]   r_act_dp;
    logic [DIGITS-1:0]   r_act_en;
    logic [4*DIGITS-1:0] r_pend_data;
    logic [DIGITS-1:0]   r_pend_dp;
    logic [DIGITS-1:0]   r_pend_en;
    logic                r_pend_valid;

    logic                w_slot_end;
    logic                w_frame_end;
    logic                w_in_blank;
    logic                w_suppress;
    logic                w_show;
    logic [3:0]          w_slot_nib;
    logic [DIGITS-1:0]   w_an_on;
    logic [6:0]          w_seg_dec;

    function automatic logic [6:0] decodeHex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_slot_end  = (r_div_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_idx     <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // A load landing on the commit edge goes straight to the active buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_en    <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_frame_end) begin
            if (load) begin
                r_act_data <= data_in;
                r_act_dp   <= dp_in;
                r_act_en   <= en_in;
            end else if (r_pend_valid) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
                r_act_en   <= r_pend_en;
            end
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_data  <= data_in;
            r_pend_dp    <= dp_in;
            r_pend_en    <= en_in;
            r_pend_valid <= 1'b1;
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_in_blank = 1'b0;
        end else begin : g_blank
            assign w_in_blank = (r_div_cnt < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef SEG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0] w_lz_dark;

    // A digit stays "leading" only while every enabled digit above it is a plain zero.
    always_comb begin : lzMask
        logic highZero;
        w_lz_dark = '0;
        highZero  = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            w_lz_dark[k] = highZero && (r_act_data[4*k +: 4] == 4'h0) && !r_act_dp[k];
            if (r_act_en[k] && ((r_act_data[4*k +: 4] != 4'h0) || r_act_dp[k])) begin
                highZero = 1'b0;
            end
        end
    end

    assign w_suppress = w_lz_dark[r_idx];
`else
    assign w_suppress = 1'b0;
`endif

    assign w_slot_nib = r_act_data[r_idx*4 +: 4];
    assign w_seg_dec  = decodeHex(w_slot_nib);
    assign w_an_on    = ~(DIGITS'(1) << r_idx);
    assign w_show     = !w_in_blank && r_act_en[r_idx] && !w_suppress;

    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_frame_end;
            if (w_show) begin
                an  <= w_an_on;
                seg <= {~r_act_dp[r_idx], w_seg_dec};
            end else begin
                an  <= '1;
                seg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
// Expectations follow the SEG_LZ_SUPPRESS_EN setting of the build.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int sampleNo = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .DIGITS(4),
        .SCAN_DIV(4),
        .BLANK_CYCLES(1),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .data_in(data_in),
        .dp_in(dp_in),
        .en_in(en_in),
        .an(an),
        .seg(seg),
        .frame_tick(frame_tick)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s (sample %0d): got %0h expected %0h", tag, sampleNo, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sampleNo++;
    endtask

    // Presents a load for exactly one edge.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        load    = 1'b1;
        data_in = d;
        dp_in   = dp;
        en_in   = en;
        tick();
        load    = 1'b0;
    endtask

    task automatic waitFrame();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("waitFrame", {31'd0, frame_tick}, 32'd1);
    endtask

    // Starts right after a frame_tick sample; checks all 16 cycles of the frame.
    // s0..s3 are the expected lit seg values per digit, FF meaning dark.
    task automatic checkFrame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input int ldJ, input logic [15:0] ldData,
                              input logic [3:0] ldDp, input logic [3:0] ldEn,
                              input int ldJ2, input logic [15:0] ldData2);
        logic [7:0] segTab [4];
        logic [3:0] expAn;
        logic [7:0] expSeg;
        int d;
        int div;
        segTab[0] = s0;
        segTab[1] = s1;
        segTab[2] = s2;
        segTab[3] = s3;
        for (int j = 1; j <= 16; j++) begin
            d   = (j - 1) / 4;
            div = (j - 1) % 4;
            if (j == ldJ) begin
                load = 1'b1; data_in = ldData; dp_in = ldDp; en_in = ldEn;
            end else if (j == ldJ2) begin
                load = 1'b1; data_in = ldData2; dp_in = 4'h0; en_in = 4'hF;
            end
            tick();
            load = 1'b0;
            if (div == 0 || segTab[d] == 8'hFF) begin
                expAn  = 4'hF;
                expSeg = 8'hFF;
            end else begin
                expAn  = ~(4'b0001 << d);
                expSeg = segTab[d];
            end
            checkOutput("an", {28'd0, an}, {28'd0, expAn});
            checkOutput("seg", {24'd0, seg}, {24'd0, expSeg});
            checkOutput("frame_tick", {31'd0, frame_tick}, (j == 16) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int firstTick;
        logic darkOk;
        logic [7:0] lzHigh;

`ifdef SEG_LZ_SUPPRESS_EN
        lzHigh = 8'hFF;
`else
        lzHigh = 8'hC0;
`endif
        rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; en_in = '0;

        // Reset values, then first frame_tick 16 cycles after release with a dark display
        repeat (3) tick();
        checkOutput("reset_an", {28'd0, an}, 32'hF);
        checkOutput("reset_seg", {24'd0, seg}, 32'hFF);
        checkOutput("reset_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;
        firstTick = -1;
        darkOk = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (an !== 4'hF || seg !== 8'hFF) darkOk = 1'b0;
            if (frame_tick === 1'b1) begin
                firstTick = n;
                break;
            end
        end
        checkOutput("first_tick_cycle", firstTick, 32'd16);
        checkOutput("dark_after_reset", {31'd0, darkOk}, 32'd1);

        // 12AF with dp on digit 2; during that frame, loads at idx=1 and idx=2 must not tear it
        applyStimulus(16'h12AF, 4'b0100, 4'hF);
        waitFrame();
        checkFrame(8'h8E, 8'h88, 8'h24, 8'hF9, 6, 16'h0000, 4'h0, 4'hF, 10, 16'h8888);

        // Last write wins; load on the commit edge is taken directly
        checkFrame(8'h80, 8'h80, 8'h80, 8'h80, 16, 16'h5555, 4'h0, 4'hF, -1, 16'h0);
        checkOutput("pend_valid_after_bypass", {31'd0, dut.r_pend_valid}, 32'd0);

        // Digit enables 1010
        checkFrame(8'h92, 8'h92, 8'h92, 8'h92, 1, 16'h12AF, 4'h0, 4'b1010, -1, 16'h0);
        checkFrame(8'hFF, 8'h88, 8'hFF, 8'hF9, 1, 16'h0070, 4'h0, 4'hF, -1, 16'h0);

        // Leading zeros
        checkFrame(8'hC0, 8'hF8, lzHigh, lzHigh, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

        // Mid-frame reset discards a pending load
        applyStimulus(16'h8888, 4'h0, 4'hF);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset_an", {28'd0, an}, 32'hF);
        checkOutput("midreset_seg", {24'd0, seg}, 32'hFF);
        checkOutput("midreset_tick", {31'd0, frame_tick}, 32'd0);
        firstTick = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (frame_tick === 1'b1) begin
                firstTick = n;
                break;
            end
        end
        checkOutput("midreset_first_tick", firstTick, 32'd16);
        checkFrame(8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised, time-multiplexed seven-segment scan controller driving the board `an`/`seg` pins.
- Called from the CPU top in place of the fixed 8-digit scanner; the display value comes from the `led`/debug path.
- Generalises the scanner in digit count, refresh rate and blanking gap.
- Double-buffers the display value so CPU writes never tear a frame.

Parameters:
- DIGITS, 8, number of digits scanned (1..8).
- SCAN_DIV, 50000, clk cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 2500, cycles at the start of each slot with all anodes off (anti-ghosting); 0 means no gap.
- CNT_W, 16, width of the slot divider counter; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- load  in  1  one-cycle strobe; capture data_in/dp_in/en_in into the pending buffer
- data_in  in  4*DIGITS  hex nibbles; nibble k drives digit k
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- en_in  in  DIGITS  digit enable, 0 = digit permanently dark
- an  out  DIGITS  anodes, active-low
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (synchronous, next edge):
  - an = all 1; seg = 8'hFF; frame_tick = 0.
  - div_cnt = 0; idx = 0.
  - Active and pending buffers cleared; pending_valid = 0.
- div_cnt counts 0..SCAN_DIV-1, then wraps to 0.
- At the wrap, idx advances; idx wraps from DIGITS-1 to 0.
- Frame length is exactly DIGITS*SCAN_DIV cycles.
- Outputs are registered with 1-cycle latency from (div_cnt, idx):
  - div_cnt < BLANK_CYCLES: an = all 1, seg = 8'hFF.
  - Otherwise: an = ~(1<<idx), seg = {~dp[idx], decode(nibble[idx])}.
  - If active en[idx] = 0: an = all 1 and seg = 8'hFF for the whole slot.
- Decode (seg[6:0], active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- load:
  - Copies inputs into pending and sets pending_valid.
  - A second load before the commit overwrites pending; last write wins.
- Commit happens on the edge where div_cnt = SCAN_DIV-1 and idx = DIGITS-1:
  - If pending_valid: pending is copied to active and pending_valid is cleared.
  - frame_tick = 1 for the cycle after that edge, regardless of pending_valid.
- load on the commit edge: the committed value is the one presented that cycle, i.e. the bypass wins; pending_valid ends at 0.
- Active data never changes mid-frame.
- DIGITS = 1: idx stays 0; every slot end is a frame end.
- rst asserted mid-frame: all state is cleared on that edge; a pending load is discarded.

Optional Feature:
- Macro: SEG_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression.
  - Any digit k > 0 whose nibble is 0 and all of whose higher enabled digits are also 0 is shown dark (an bit 1, seg FF).
  - Digit 0 is always shown.
  - A lit dp on a suppressed digit keeps it shown.
  - The suppression mask is computed from the active buffer only.
- Not defined: every enabled digit is shown as decoded. There is no extra logic and no extra ports.

Test Plan (DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, frame = 16 cycles):
1. Reset held 3 cycles, then released -> an=4'hF, seg=8'hFF; the first frame_tick appears 16 cycles after release; the display stays dark because active=0 and en=0.
2. load data=16'h12AF, en=4'hF, dp=4'b0100 after reset -> from the next frame, each slot shows 1 blank cycle then 3 lit cycles:
   - an=E, seg=8E (F)
   - an=D, seg=88 (A)
   - an=B, seg=24 (2, dp lit, bit 7 = 0)
   - an=7, seg=F9 (1)
3. Tearing check: load 16'h0000 at mid-frame (idx=1), then load 16'h8888 at idx=2 -> the remaining slots still show 12AF; the next frame shows 8 on every digit (seg=80).
4. load asserted on the exact commit edge with 16'h5555 -> the next frame shows 5 on all digits (seg=92); pending_valid=0 afterwards.
5. en=4'b1010 -> an never goes to E or B; in those slots an=F and seg=FF.
6. With SEG_LZ_SUPPRESS_EN defined, data=16'h0070, en=F, dp=0:
   - digits 3 and 2 are dark.
   - digit 1 shows 7 (seg=F8).
   - digit 0 shows 0 (seg=C0).
   - Without the macro, digits 3 and 2 show seg=C0.
